// File: rtl/expr_recognizer_if.sv
// Character-stream bus for expr_recognizer: characters and restart in, recogniser status out.
interface expr_recognizer_if #(
    parameter int MAX_DEPTH = 4,
    parameter int CNT_W     = 8
);
    localparam int DW = $clog2(MAX_DEPTH + 1);

    logic             restart;
    logic             in_valid;
    logic [7:0]       in;
    logic             accept;
    logic             error;
    logic [DW-1:0]    depth;
    logic [CNT_W-1:0] operand_cnt;

    modport master (
        output restart, in_valid, in,
        input  accept, error, depth, operand_cnt
    );

    modport slave (
        input  restart, in_valid, in,
        output accept, error, depth, operand_cnt
    );
endinterface

// File: rtl/expr_recognizer.sv
// Streaming recogniser for arithmetic expressions with nested parentheses and multi-digit operands.
// Optional build macro EXPR_SPACE_SKIP_EN: spaces are whitespace, but a space may not split an operand.
module expr_recognizer #(
    parameter int MAX_DEPTH     = 4,
    parameter int MAX_DIGITS    = 8,
    parameter int CNT_W         = 8,
    parameter int ALLOW_SUB_DIV = 0
) (
    input  logic               clk,
    input  logic               clr_n,
    expr_recognizer_if.slave   bus
);
    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam int GW = $clog2(MAX_DIGITS + 1);

    localparam logic [DW-1:0]    DEPTH_MAX  = DW'(MAX_DEPTH);
    localparam logic [DW-1:0]    DEPTH_ZERO = {DW{1'b0}};
    localparam logic [GW-1:0]    DIGITS_MAX = GW'(MAX_DIGITS);
    localparam logic [GW-1:0]    DIGITS_ONE = GW'(1);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
    localparam bit               SUB_DIV_EN = (ALLOW_SUB_DIV != 32'sd0);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_NUM   = 3'd1,
        S_OP    = 3'd2,
        S_LP    = 3'd3,
        S_RP    = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t           r_state;
    logic [DW-1:0]    r_depth;
    logic [GW-1:0]    r_digits;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sep;

    logic w_is_digit;
    logic w_is_op;
    logic w_is_lp;
    logic w_is_rp;
    logic w_is_space;

    // Character classification of the incoming byte.
    always_comb begin
        w_is_digit = (bus.in >= 8'd48) && (bus.in <= 8'd57);
        w_is_op    = (bus.in == 8'd42) || (bus.in == 8'd43) ||
                     (SUB_DIV_EN && ((bus.in == 8'd45) || (bus.in == 8'd47)));
        w_is_lp    = (bus.in == 8'd40);
        w_is_rp    = (bus.in == 8'd41);
`ifdef EXPR_SPACE_SKIP_EN
        w_is_space = (bus.in == 8'd32);
`else
        w_is_space = 1'b0;
`endif
    end

    // Recogniser FSM with depth, operand-length and operand-count tracking.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= S_START;
            r_depth  <= DEPTH_ZERO;
            r_digits <= {GW{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_sep    <= 1'b0;
        end else if (bus.restart) begin
            r_state  <= S_START;
            r_depth  <= DEPTH_ZERO;
            r_digits <= {GW{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_sep    <= 1'b0;
        end else if (bus.in_valid) begin
            if (w_is_space) begin
                // A space only matters after a digit: it forbids continuing that operand.
                if (r_state == S_NUM) begin
                    r_sep <= 1'b1;
                end
            end else begin
                r_sep <= 1'b0;
                case (r_state)
                    S_START, S_OP, S_LP: begin
                        if (w_is_digit) begin
                            r_state  <= S_NUM;
                            r_digits <= DIGITS_ONE;
                            if (r_cnt != CNT_SAT) begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end else if (w_is_lp && (r_depth != DEPTH_MAX)) begin
                            r_state <= S_LP;
                            r_depth <= r_depth + 1'b1;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                    S_NUM: begin
                        if (w_is_digit) begin
                            if (r_sep || (r_digits == DIGITS_MAX)) begin
                                r_state <= S_ERR;
                            end else begin
                                r_digits <= r_digits + 1'b1;
                            end
                        end else if (w_is_op) begin
                            r_state <= S_OP;
                        end else if (w_is_rp && (r_depth != DEPTH_ZERO)) begin
                            r_state <= S_RP;
                            r_depth <= r_depth - 1'b1;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                    S_RP: begin
                        if (w_is_op) begin
                            r_state <= S_OP;
                        end else if (w_is_rp && (r_depth != DEPTH_ZERO)) begin
                            r_state <= S_RP;
                            r_depth <= r_depth - 1'b1;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                    S_ERR: begin
                        r_state <= S_ERR;
                    end
                    default: begin
                        r_state <= S_ERR;
                    end
                endcase
            end
        end
    end

    assign bus.accept      = ((r_state == S_NUM) || (r_state == S_RP)) && (r_depth == DEPTH_ZERO);
    assign bus.error       = (r_state == S_ERR);
    assign bus.depth       = r_depth;
    assign bus.operand_cnt = r_cnt;
endmodule

// File: tb/tb_expr_recognizer.sv
// Self-checking bench: two recognisers (without/with '-' '/') against a prefix-rescanning reference model.
module tb_expr_recognizer;
    localparam int MAX_DEPTH  = 4;
    localparam int MAX_DIGITS = 8;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef EXPR_SPACE_SKIP_EN
    localparam bit SPACE_SKIP = 1'b1;
`else
    localparam bit SPACE_SKIP = 1'b0;
`endif

    logic clk;
    logic clr_n;

    expr_recognizer_if #(.MAX_DEPTH(MAX_DEPTH), .CNT_W(CNT_W)) if0 ();
    expr_recognizer_if #(.MAX_DEPTH(MAX_DEPTH), .CNT_W(CNT_W)) if1 ();

    expr_recognizer #(
        .MAX_DEPTH(MAX_DEPTH), .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W), .ALLOW_SUB_DIV(0)
    ) dut0 (
        .clk(clk), .clr_n(clr_n), .bus(if0)
    );

    expr_recognizer #(
        .MAX_DEPTH(MAX_DEPTH), .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W), .ALLOW_SUB_DIV(1)
    ) dut1 (
        .clk(clk), .clr_n(clr_n), .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Characters accepted since the last restart/reset; the model rescans this whole prefix.
    byte q[$];

    typedef struct {
        string s;
        bit    a0; bit e0; int d0; int c0;
        bit    a1; bit e1; int d1; int c1;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Grammar view: a prefix is judged by which kind of token each character may follow.
    function automatic void model(input bit allow, output bit acc, output bit err,
                                  output int dep, output int cnt);
        int  prev;  // 0 start, 1 digit, 2 operator, 3 '(', 4 ')'
        int  run;
        bit  sep;
        byte c;
        bit  is_op;
        prev = 0; dep = 0; cnt = 0; run = 0; sep = 1'b0; err = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            if (!err) begin
                c     = q[i];
                is_op = (c == 8'd42) || (c == 8'd43) || (allow && ((c == 8'd45) || (c == 8'd47)));
                if (SPACE_SKIP && (c == 8'd32)) begin
                    if (prev == 1) sep = 1'b1;
                end else if (c >= 8'd48 && c <= 8'd57) begin
                    if (prev == 0 || prev == 2 || prev == 3) begin
                        run = 1;
                        if (cnt < CNT_MAX) cnt++;
                        prev = 1; sep = 1'b0;
                    end else if (prev == 1 && !sep && run < MAX_DIGITS) begin
                        run++;
                    end else begin
                        err = 1'b1;
                    end
                end else if (is_op) begin
                    if (prev == 1 || prev == 4) begin prev = 2; sep = 1'b0; end
                    else err = 1'b1;
                end else if (c == 8'd40) begin
                    if ((prev == 0 || prev == 2 || prev == 3) && dep < MAX_DEPTH) begin
                        dep++; prev = 3;
                    end else err = 1'b1;
                end else if (c == 8'd41) begin
                    if ((prev == 1 || prev == 4) && dep > 0) begin
                        dep--; prev = 4; sep = 1'b0;
                    end else err = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end
        end
        acc = !err && (prev == 1 || prev == 4) && (dep == 0);
    endfunction

    task automatic check_model(input string tag);
        bit a, e; int d, c;
        model(1'b0, a, e, d, c);
        chk({tag, " acc0"}, int'(if0.accept), int'(a));
        chk({tag, " err0"}, int'(if0.error), int'(e));
        chk({tag, " dep0"}, int'(if0.depth), d);
        chk({tag, " cnt0"}, int'(if0.operand_cnt), c);
        model(1'b1, a, e, d, c);
        chk({tag, " acc1"}, int'(if1.accept), int'(a));
        chk({tag, " err1"}, int'(if1.error), int'(e));
        chk({tag, " dep1"}, int'(if1.depth), d);
        chk({tag, " cnt1"}, int'(if1.operand_cnt), c);
    endtask

    task automatic drive(input bit rs, input bit v, input byte c);
        if0.restart = rs; if0.in_valid = v; if0.in = c;
        if1.restart = rs; if1.in_valid = v; if1.in = c;
    endtask

    task automatic cycle(input bit rs, input bit v, input byte c, input string tag);
        drive(rs, v, c);
        @(posedge clk);
        #1;
        if (rs) q.delete();
        else if (v) q.push_back(c);
        drive(1'b0, 1'b0, 8'd0);
        check_model(tag);
    endtask

    task automatic feed(input string s, input string tag);
        cycle(1'b1, 1'b0, 8'd0, {tag, " rst"});
        for (int j = 0; j < s.len(); j++) cycle(1'b0, 1'b1, s[j], tag);
    endtask

    initial begin
        string  alpha;
        bit     exp_acc[4];
        int     exp_dep[9];
        string  s;

        tbl[0]  = '{"12+3",      1, 0, 0, 2, 1, 0, 0, 2};
        tbl[1]  = '{"(4*(5+6))", 1, 0, 0, 3, 1, 0, 0, 3};
        tbl[2]  = '{"(((((",     0, 1, 4, 0, 0, 1, 4, 0};
        tbl[3]  = '{"999999999", 0, 1, 0, 1, 0, 1, 0, 1};
        tbl[4]  = '{"99999999",  1, 0, 0, 1, 1, 0, 0, 1};
        tbl[5]  = '{"3)",        0, 1, 0, 1, 0, 1, 0, 1};
        tbl[6]  = '{"8-2",       0, 1, 0, 1, 1, 0, 0, 2};
        tbl[7]  = '{"9/(3",      0, 1, 0, 1, 0, 0, 1, 2};
        tbl[8]  = '{"1 2",       0, 1, 0, 1, 0, 1, 0, 1};
        tbl[9]  = '{"(1+2)*",    0, 0, 0, 2, 0, 0, 0, 2};
        tbl[10] = '{"((7))",     1, 0, 0, 1, 1, 0, 0, 1};
        tbl[11] = '{"+1",        0, 1, 0, 0, 0, 1, 0, 0};
        tbl[12] = '{"(1)(",      0, 1, 0, 1, 0, 1, 0, 1};
        tbl[13] = '{"12a",       0, 1, 0, 1, 0, 1, 0, 1};
        tbl[14] = '{"(()",       0, 1, 2, 0, 0, 1, 2, 0};

        exp_acc = '{1'b1, 1'b1, 1'b0, 1'b1};
        exp_dep = '{1, 1, 1, 2, 2, 2, 2, 1, 0};

        clr_n = 1'b0;
        drive(1'b0, 1'b0, 8'd0);
        #3;
        chk("reset acc", int'(if0.accept), 0);
        chk("reset err", int'(if0.error), 0);
        chk("reset dep", int'(if0.depth), 0);
        chk("reset cnt", int'(if0.operand_cnt), 0);
        #8 clr_n = 1'b1;
        @(posedge clk); #1;
        check_model("idle");

        foreach (tbl[i]) begin
            feed(tbl[i].s, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d end acc0", i), int'(if0.accept), int'(tbl[i].a0));
            chk($sformatf("tbl%0d end err0", i), int'(if0.error), int'(tbl[i].e0));
            chk($sformatf("tbl%0d end dep0", i), int'(if0.depth), tbl[i].d0);
            chk($sformatf("tbl%0d end cnt0", i), int'(if0.operand_cnt), tbl[i].c0);
            chk($sformatf("tbl%0d end acc1", i), int'(if1.accept), int'(tbl[i].a1));
            chk($sformatf("tbl%0d end err1", i), int'(if1.error), int'(tbl[i].e1));
            chk($sformatf("tbl%0d end dep1", i), int'(if1.depth), tbl[i].d1);
            chk($sformatf("tbl%0d end cnt1", i), int'(if1.operand_cnt), tbl[i].c1);
        end

        // "12+3": accept after every character
        s = "12+3";
        cycle(1'b1, 1'b0, 8'd0, "seqA rst");
        for (int j = 0; j < 4; j++) begin
            cycle(1'b0, 1'b1, s[j], "seqA");
            chk($sformatf("seqA acc[%0d]", j), int'(if0.accept), int'(exp_acc[j]));
        end

        // "(4*(5+6))": depth after every character
        s = "(4*(5+6))";
        cycle(1'b1, 1'b0, 8'd0, "seqB rst");
        for (int j = 0; j < 9; j++) begin
            cycle(1'b0, 1'b1, s[j], "seqB");
            chk($sformatf("seqB dep[%0d]", j), int'(if0.depth), exp_dep[j]);
        end

        // restart wins over a simultaneous character
        feed("(((((", "seqC");
        chk("seqC err", int'(if0.error), 1);
        cycle(1'b1, 1'b1, 8'd55, "seqC restart7");
        chk("seqC dep", int'(if0.depth), 0);
        chk("seqC acc", int'(if0.accept), 0);
        chk("seqC errclr", int'(if0.error), 0);
        chk("seqC cnt", int'(if0.operand_cnt), 0);

        // idle gaps between characters
        s = "8-2";
        cycle(1'b1, 1'b0, 8'd0, "seqD rst");
        for (int j = 0; j < 3; j++) begin
            cycle(1'b0, 1'b1, s[j], "seqD");
            cycle(1'b0, 1'b0, byte'($urandom_range(0, 255)), "seqD gap");
            cycle(1'b0, 1'b0, 8'd43, "seqD gap");
        end
        chk("seqD acc1", int'(if1.accept), 1);
        chk("seqD err0", int'(if0.error), 1);

        // asynchronous clear between clock edges
        feed("(12", "seqE");
        #2 clr_n = 1'b0;
        #1;
        chk("seqE async acc", int'(if1.accept), 0);
        chk("seqE async err", int'(if0.error), 0);
        chk("seqE async dep", int'(if0.depth), 0);
        chk("seqE async cnt", int'(if0.operand_cnt), 0);
        #1 clr_n = 1'b1;
        q.delete();
        cycle(1'b0, 1'b1, 8'd53, "seqE after");
        chk("seqE after acc", int'(if0.accept), 1);

`ifdef EXPR_SPACE_SKIP_EN
        feed("1 + 2", "spA");
        chk("space accept", int'(if0.accept), 1);
        chk("space cnt", int'(if0.operand_cnt), 2);
        feed("1 2", "spB");
        chk("space split err", int'(if0.error), 1);
`else
        feed("1 +", "spA");
        chk("space is other", int'(if0.error), 1);
`endif

        // random characters, gaps and restarts against the model
        alpha = "0123456789+*-/()(( x)9";
        cycle(1'b1, 1'b0, 8'd0, "rnd rst");
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0)
                cycle(1'b1, $urandom_range(0, 1) == 1, alpha[$urandom_range(0, alpha.len() - 1)], "rnd");
            else if ($urandom_range(0, 3) == 0)
                cycle(1'b0, 1'b0, byte'($urandom_range(0, 255)), "rnd");
            else
                cycle(1'b0, 1'b1, alpha[$urandom_range(0, alpha.len() - 1)], "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
